// File: rtl/note_player_pkg.sv
// note_player_pkg
//   Shared types and default widths for the note player tone stage.
//   state_t    : FSM encoding (IDLE, PLAY, GAP), also exposed for debug.
//   note_cmd_t : one note command as presented by the sequencer.
//   The NP_* widths are the default parameter values. They are also the field
//   widths of note_cmd_t, so the top-level widths must not exceed them.
package note_player_pkg;

  localparam int NP_PERIOD_W = 16;
  localparam int NP_DUR_W    = 12;
  localparam int NP_TPM_W    = 16;
  localparam int NP_GAP_MS   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [NP_PERIOD_W-1:0] half_period;
    logic                   rest;
    logic [NP_DUR_W-1:0]    duration_ms;
  } note_cmd_t;

endpackage

// File: rtl/ms_ticker.sv
// ms_ticker
//   Millisecond prescaler. On start it latches the cycles-per-ms value
//   (0 is treated as 1) and clears its count. While enabled it counts
//   0..T-1 and raises ms_tick combinationally during the cycle the count
//   equals T-1, then wraps to 0.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : clear count and latch tpm
//   clear        : clear count only (keeps latched T)
//   enable       : advance the count
//   tpm          : cycles per ms, sampled on start
//   ms_tick      : one-cycle pulse at the end of each ms
module ms_ticker #(
  parameter int TPM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             enable,
  input  logic [TPM_W-1:0] tpm,
  output logic             ms_tick
);

  localparam logic [TPM_W-1:0] TPM_ONE = TPM_W'(1);

  logic [TPM_W-1:0] t_q;
  logic [TPM_W-1:0] cnt_q;

  assign ms_tick = enable && (cnt_q == (t_q - TPM_ONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_q   <= TPM_ONE;
      cnt_q <= '0;
    end else if (start) begin
      t_q   <= (tpm == '0) ? TPM_ONE : tpm;
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      // Reload at the terminal value so the counter never wraps on its own.
      cnt_q <= ms_tick ? '0 : (cnt_q + TPM_ONE);
    end
  end

endmodule

// File: rtl/note_player.sv
// note_player
//   Square-wave tone stage. Accepts one note command, plays it for its
//   duration in ms (tone or silence), then holds a fixed silent gap of
//   GAP_MS ms before returning to IDLE with a one-cycle note_done pulse.
//
//   Handshake: a command transfers on the rising edge where note_valid and
//   note_ready are both high. note_ready depends only on state, rst_n and
//   stop (never on note_valid), so the sequencer may hold note_valid high
//   and the next command is taken in the note_done cycle without a bubble.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   ticks_per_milli   : clk cycles per ms, latched on accept (0 -> 1)
//   note_valid/ready  : command handshake
//   note_half_period  : tone half period in cycles (0 -> silent)
//   note_rest         : silent note
//   note_duration_ms  : note length in ms (0 -> immediate note_done)
//   stop              : synchronous abort, also blocks acceptance
//   sound             : speaker drive (registered)
//   playing           : high in PLAY and GAP (registered)
//   note_done         : completion pulse (registered)
//   fsm_state         : current FSM state, for debug/observation
module note_player
  import note_player_pkg::*;
#(
  parameter int PERIOD_W = NP_PERIOD_W,
  parameter int DUR_W    = NP_DUR_W,
  parameter int TPM_W    = NP_TPM_W,
  parameter int GAP_MS   = NP_GAP_MS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TPM_W-1:0]    ticks_per_milli,
  input  logic                note_valid,
  output logic                note_ready,
  input  logic [PERIOD_W-1:0] note_half_period,
  input  logic                note_rest,
  input  logic [DUR_W-1:0]    note_duration_ms,
  input  logic                stop,
  output logic                sound,
  output logic                playing,
  output logic                note_done,
  output state_t              fsm_state
);

  localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);
  localparam logic [DUR_W-1:0]    DUR_ONE    = DUR_W'(1);
  localparam logic [DUR_W-1:0]    GAP_LOAD   = DUR_W'(GAP_MS);

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] hp_q, hp_d;
  logic                rest_q, rest_d;
  logic [PERIOD_W-1:0] hp_cnt_q, hp_cnt_d;
  logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic                sound_d;
  logic                done_d;
  logic                tick_start;
  logic                tick_clear;
  logic                ms_tick;
  logic                accept;
  logic                tone_on;
  note_cmd_t           cmd_in;

  assign cmd_in = '{
    half_period: NP_PERIOD_W'(note_half_period),
    rest:        note_rest,
    duration_ms: NP_DUR_W'(note_duration_ms)
  };

  assign note_ready = (state_q == IDLE) && rst_n && !stop;
  assign accept     = note_valid && note_ready;
  assign tone_on    = (hp_q != '0) && !rest_q;
  assign fsm_state  = state_q;

  ms_ticker #(
    .TPM_W (TPM_W)
  ) u_ms_ticker (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (tick_start),
    .clear   (tick_clear),
    .enable  (state_q != IDLE),
    .tpm     (ticks_per_milli),
    .ms_tick (ms_tick)
  );

  always_comb begin
    state_d    = state_q;
    hp_d       = hp_q;
    rest_d     = rest_q;
    hp_cnt_d   = hp_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    sound_d    = sound;
    done_d     = 1'b0;
    tick_start = 1'b0;
    tick_clear = 1'b0;

    case (state_q)
      IDLE: begin
        sound_d = 1'b0;
        if (accept) begin
          tick_start = 1'b1;
          hp_d       = PERIOD_W'(cmd_in.half_period);
          rest_d     = cmd_in.rest;
          hp_cnt_d   = '0;
          dur_cnt_d  = DUR_W'(cmd_in.duration_ms);
          if (cmd_in.duration_ms == '0) begin
            // Zero-length note: nothing to play, just report completion.
            done_d = 1'b1;
          end else begin
            state_d = PLAY;
            sound_d = (cmd_in.half_period != '0) && !cmd_in.rest;
          end
        end
      end

      PLAY: begin
        if (stop) begin
          state_d = IDLE;
          sound_d = 1'b0;
        end else if (ms_tick && (dur_cnt_q == DUR_ONE)) begin
          sound_d  = 1'b0;
          hp_cnt_d = '0;
          if (GAP_MS == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = GAP;
            dur_cnt_d  = GAP_LOAD;
            tick_clear = 1'b1;
          end
        end else begin
          if (ms_tick) begin
            dur_cnt_d = dur_cnt_q - DUR_ONE;
          end
          if (!tone_on) begin
            sound_d  = 1'b0;
            hp_cnt_d = '0;
          end else if (hp_cnt_q == (hp_q - PERIOD_ONE)) begin
            sound_d  = !sound;
            hp_cnt_d = '0;
          end else begin
            hp_cnt_d = hp_cnt_q + PERIOD_ONE;
          end
        end
      end

      GAP: begin
        sound_d = 1'b0;
        if (stop) begin
          state_d = IDLE;
        end else if (ms_tick) begin
          if (dur_cnt_q == DUR_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            dur_cnt_d = dur_cnt_q - DUR_ONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        sound_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hp_q      <= '0;
      rest_q    <= 1'b0;
      hp_cnt_q  <= '0;
      dur_cnt_q <= '0;
      sound     <= 1'b0;
      playing   <= 1'b0;
      note_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      hp_q      <= hp_d;
      rest_q    <= rest_d;
      hp_cnt_q  <= hp_cnt_d;
      dur_cnt_q <= dur_cnt_d;
      sound     <= sound_d;
      playing   <= (state_d != IDLE);
      note_done <= done_d;
    end
  end

endmodule

// File: tb/tb_note_player.sv
module tb_note_player;
  import note_player_pkg::*;

  localparam int GAP_MS = 1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ticks_per_milli = 16'd4;
  logic        note_valid = 1'b0;
  logic        note_ready;
  logic [15:0] note_half_period = '0;
  logic        note_rest = 1'b0;
  logic [11:0] note_duration_ms = '0;
  logic        stop = 1'b0;
  logic        sound;
  logic        playing;
  logic        note_done;
  state_t      fsm_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  note_player #(
    .PERIOD_W (16),
    .DUR_W    (12),
    .TPM_W    (16),
    .GAP_MS   (GAP_MS)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ticks_per_milli  (ticks_per_milli),
    .note_valid       (note_valid),
    .note_ready       (note_ready),
    .note_half_period (note_half_period),
    .note_rest        (note_rest),
    .note_duration_ms (note_duration_ms),
    .stop             (stop),
    .sound            (sound),
    .playing          (playing),
    .note_done        (note_done),
    .fsm_state        (fsm_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [3:0] exp_q[$];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // ---------------- behavioural model ----------------
  // A note accepted in cycle s plays in cycles s+1..s+D*T, is silent in the
  // gap up to s+(D+G)*T, and reports done in the cycle after that.
  bit m_busy    = 1'b0;
  bit m_aud     = 1'b0;
  int m_s       = 0;
  int m_play_end = 0;
  int m_end     = 0;
  int m_hp      = 1;
  int m_done_at = -1;
  int m_t       = 1;
  bit in_busy, in_play, e_sound, e_ready;

  always @(negedge clk) begin
    in_busy = m_busy && (cyc > m_s) && (cyc <= m_end);
    in_play = m_busy && (cyc > m_s) && (cyc <= m_play_end);
    e_sound = 1'b0;
    if (in_play && m_aud) e_sound = (((cyc - m_s - 1) / m_hp) % 2) == 0;
    e_ready = rst_n && !stop && !in_busy;
    if (cyc > 0) begin
      check("sound", sound, e_sound);
      check("playing", playing, in_busy);
      check("note_done", note_done, cyc == m_done_at);
      check("note_ready", note_ready, e_ready);
    end
    if (!rst_n) begin
      m_busy    = 1'b0;
      m_done_at = -1;
    end else if (in_busy && stop) begin
      m_busy    = 1'b0;
      m_done_at = -1;
    end else if (e_ready && note_valid) begin
      m_t   = (ticks_per_milli == 0) ? 1 : int'(ticks_per_milli);
      m_s   = cyc;
      m_aud = (note_half_period != 0) && !note_rest;
      m_hp  = int'(note_half_period);
      if (note_duration_ms == 0) begin
        m_busy    = 1'b0;
        m_done_at = cyc + 1;
      end else begin
        m_busy     = 1'b1;
        m_play_end = cyc + int'(note_duration_ms) * m_t;
        m_end      = m_play_end + GAP_MS * m_t;
        m_done_at  = m_end + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int acc_cyc  = 0;
  bit acc_done = 1'b0;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a command and waits for it to be taken; returns at #1 after the
  // accepting edge with note_valid still high.
  task automatic drive_note(input int hp, input bit rest, input int dur);
    bit got;
    got = 1'b0;
    note_valid       = 1'b1;
    note_half_period = 16'(hp);
    note_rest        = rest;
    note_duration_ms = 12'(dur);
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (note_ready) begin
        got      = 1'b1;
        acc_cyc  = cyc;
        acc_done = note_done;
      end
    end
    check("accept", got, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic count_playing(output int n);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (playing) n++;
      else break;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] exp_v;
  int a1, a2, n, w, seen;

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Basic note: T=4, HP=3, D=2.
    for (int c = 1; c <= 13; c++) begin
      if (c == 13)                 exp_q.push_back(4'b0011);
      else if (c <= 3 || (c >= 7 && c <= 8)) exp_q.push_back(4'b1100);
      else                         exp_q.push_back(4'b0100);
    end
    ticks_per_milli = 16'd4;
    drive_note(3, 1'b0, 2);
    note_valid = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      check("basic_note", {sound, playing, note_done, note_ready}, exp_v);
    end
    idle(2);

    // Back-to-back with note_valid held.
    drive_note(2, 1'b0, 1);
    a1 = acc_cyc;
    drive_note(1, 1'b0, 1);
    a2 = acc_cyc;
    note_valid = 1'b0;
    check("b2b_spacing", a2 - a1, 9);
    check("b2b_done_at_accept", acc_done, 1);
    idle(12);

    // Rest of 3 ms.
    drive_note(3, 1'b1, 3);
    note_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("rest_silent", {playing, sound}, 2'b10);
    end
    idle(8);

    // Half period 0 plays silently.
    drive_note(0, 1'b0, 2);
    note_valid = 1'b0;
    idle(16);

    // Duration 0.
    drive_note(5, 1'b0, 0);
    note_valid = 1'b0;
    @(negedge clk);
    check("d0_done", {note_done, playing}, 2'b10);
    @(negedge clk);
    check("d0_after", {note_done, playing}, 2'b00);
    idle(2);

    // Stop in cycle 5 of the basic note.
    drive_note(3, 1'b0, 2);
    note_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    check("stop_idle", {sound, playing, note_ready}, 3'b001);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (note_done) seen = 1;
    end
    check("stop_no_done", seen, 0);
    idle(1);

    // Stop with valid in IDLE blocks acceptance.
    stop = 1'b1;
    note_valid = 1'b1;
    note_duration_ms = 12'd1;
    @(negedge clk);
    check("stop_blocks_ready", note_ready, 0);
    @(posedge clk);
    #1 stop = 1'b0;
    note_valid = 1'b0;
    @(negedge clk);
    check("stop_no_accept", playing, 0);
    idle(2);

    // Reset mid-note.
    drive_note(2, 1'b0, 3);
    note_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_ready_low", note_ready, 0);
    @(negedge clk);
    check("rst_outputs", {sound, playing, note_ready}, 3'b000);
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", note_ready, 1);
    idle(1);
    drive_note(2, 1'b0, 1);
    note_valid = 1'b0;
    idle(12);

    // ticks_per_milli changed mid-note; then zero.
    ticks_per_milli = 16'd4;
    drive_note(1, 1'b0, 1);
    note_valid = 1'b0;
    ticks_per_milli = 16'd8;
    count_playing(n);
    check("tpm_latched_len", n, 8);
    drive_note(1, 1'b0, 1);
    note_valid = 1'b0;
    count_playing(n);
    check("tpm_new_len", n, 16);
    ticks_per_milli = 16'd0;
    drive_note(1, 1'b0, 2);
    note_valid = 1'b0;
    count_playing(n);
    check("tpm_zero_len", n, 3);
    idle(2);

    // Randomized traffic with stops, resets and tpm changes.
    for (int i = 0; i < 60; i++) begin
      ticks_per_milli = 16'($urandom_range(0, 5));
      drive_note($urandom_range(0, 5), ($urandom_range(0, 5) == 0), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) continue;
      note_valid = 1'b0;
      w = $urandom_range(0, 12);
      for (int k = 0; k < w; k++) begin
        case ($urandom_range(0, 19))
          0: stop = 1'b1;
          1: rst_n = 1'b0;
          2: ticks_per_milli = 16'($urandom_range(0, 9));
          default: ;
        endcase
        @(posedge clk);
        #1;
        stop  = 1'b0;
        rst_n = 1'b1;
      end
    end
    note_valid = 1'b0;
    stop = 1'b0;
    idle(60);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
